// File: rtl/vga_sync_decoder.sv
// Receive-side 640x480 timing monitor: rebuilds x/y/active from hsync/vsync
// edges, checks line and frame timing, and declares lock after clean frames.
module vga_sync_decoder #(
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hs_in,
  input  logic       vs_in,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  output logic       locked,
  output logic       frame_start,
  output logic       sync_err
);

  localparam int unsigned CNT_W  = 10;
  localparam int unsigned SUM_W  = 11;
  localparam int unsigned GOOD_W = 3;
  localparam int unsigned GS_W   = 4;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_PRE   = CNT_MAX - CNT_W'(1);
  localparam logic [SUM_W-1:0] H_TOTAL_S = SUM_W'(H_TOTAL);
  localparam logic [SUM_W-1:0] H_SYNC_S  = SUM_W'(H_SYNC);
  localparam logic [SUM_W-1:0] V_TOTAL_S = SUM_W'(V_TOTAL);
  localparam logic [SUM_W-1:0] V_SYNC_S  = SUM_W'(V_SYNC);
  localparam logic [SUM_W-1:0] X_LO      = SUM_W'(H_SYNC + H_BP);
  localparam logic [SUM_W-1:0] X_HI      = SUM_W'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [SUM_W-1:0] Y_LO      = SUM_W'(V_SYNC + V_BP);
  localparam logic [SUM_W-1:0] Y_HI      = SUM_W'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [GS_W-1:0]  LOCK_S    = GS_W'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t              state;
  logic                hs_q;
  logic                vs_q;
  logic [CNT_W-1:0]    h_cnt;
  logic [CNT_W-1:0]    v_cnt;
  logic [CNT_W-1:0]    h_nxt;
  logic [CNT_W-1:0]    v_nxt;
  logic [GOOD_W-1:0]   good_cnt;
  logic                frame_ok;
  logic                hfall;
  logic                hrise;
  logic                vfall;
  logic                vrise;
  logic [SUM_W-1:0]    h_sum;
  logic [SUM_W-1:0]    v_sum;
  logic [GS_W-1:0]     good_sum;
  logic                timeout;
  logic                line_err;
  logic                frame_err;
  logic                any_err;
  logic                run_ok;
  logic                win_nxt;

  assign x = h_cnt;
  assign y = v_cnt;

  // Edge detection, counter next values and the timing checks for this sample.
  always_comb begin
    hfall    = ~hs_in & hs_q;
    hrise    = hs_in & ~hs_q;
    vfall    = ~vs_in & vs_q;
    vrise    = vs_in & ~vs_q;
    h_sum    = SUM_W'(h_cnt) + SUM_W'(1);
    v_sum    = SUM_W'(v_cnt) + SUM_W'(1);
    good_sum = GS_W'(good_cnt) + GS_W'(1);

    h_nxt = h_cnt;
    if (hfall) begin
      h_nxt = '0;
    end else if (h_cnt != CNT_MAX) begin
      h_nxt = h_cnt + CNT_W'(1);
    end

    v_nxt = v_cnt;
    if (vfall) begin
      v_nxt = '0;
    end else if (hfall && (v_cnt != CNT_MAX)) begin
      v_nxt = v_cnt + CNT_W'(1);
    end

    // Fires once, on the step into saturation.
    timeout   = ~hfall & (h_cnt == CNT_PRE);
    line_err  = (hfall & (h_sum != H_TOTAL_S)) |
                (hrise & (h_sum != H_SYNC_S)) |
                timeout;
    frame_err = (vfall & (v_sum != V_TOTAL_S)) |
                (vrise & (v_sum != V_SYNC_S)) |
                ((vfall | vrise) & ~hfall);
    any_err   = line_err | frame_err;
    run_ok    = frame_ok & ~any_err;

    win_nxt = (SUM_W'(h_nxt) >= X_LO) & (SUM_W'(h_nxt) < X_HI) &
              (SUM_W'(v_nxt) >= Y_LO) & (SUM_W'(v_nxt) < Y_HI);
  end

  // Counters, lock FSM and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SEARCH;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      h_cnt       <= '0;
      v_cnt       <= '0;
      good_cnt    <= '0;
      frame_ok    <= 1'b0;
      active      <= 1'b0;
      locked      <= 1'b0;
      frame_start <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      hs_q        <= hs_in;
      vs_q        <= vs_in;
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      frame_start <= vfall;
      sync_err    <= 1'b0;
      active      <= 1'b0;

      case (state)
        SEARCH: begin
          if (vfall) begin
            state    <= MEASURE;
            good_cnt <= '0;
            frame_ok <= 1'b1;
          end
        end

        MEASURE: begin
          sync_err <= any_err;
          if (timeout) begin
            state <= SEARCH;
          end else if (vfall) begin
            if (run_ok && (good_sum == LOCK_S)) begin
              state  <= LOCKED;
              locked <= 1'b1;
              active <= win_nxt;
            end else begin
              good_cnt <= run_ok ? (good_cnt + GOOD_W'(1)) : '0;
              frame_ok <= 1'b1;
            end
          end else if (any_err) begin
            frame_ok <= 1'b0;
          end
        end

        LOCKED: begin
          if (any_err) begin
            sync_err <= 1'b1;
            state    <= SEARCH;
            locked   <= 1'b0;
          end else begin
            active <= win_nxt;
          end
        end

        default: begin
          state  <= SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a shrunken raster: directed frame table,
// hand sequences for timeout and async reset, then randomized frames.
module tb_vga_sync_decoder;

  localparam int HS  = 8;
  localparam int HBP = 6;
  localparam int HA  = 20;
  localparam int HT  = 40;
  localparam int VS  = 2;
  localparam int VBP = 3;
  localparam int VA  = 10;
  localparam int VT  = 18;
  localparam int LF  = 2;
  localparam int XLO = HS + HBP;
  localparam int XHI = XLO + HA;
  localparam int YLO = VS + VBP;
  localparam int YHI = YLO + VA;

  logic       clk = 1'b0;
  logic       rst;
  logic       hs_in;
  logic       vs_in;
  logic [9:0] x;
  logic [9:0] y;
  logic       active;
  logic       locked;
  logic       frame_start;
  logic       sync_err;

  always #5 clk = ~clk;

  vga_sync_decoder #(
    .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA), .H_TOTAL(HT),
    .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA), .V_TOTAL(VT),
    .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .rst(rst), .hs_in(hs_in), .vs_in(vs_in),
    .x(x), .y(y), .active(active), .locked(locked),
    .frame_start(frame_start), .sync_err(sync_err)
  );

  typedef struct {
    int vs_lines;
    int bad_line;
    int bad_len;
    int bad_sw;
    int vf_delay;
    int exp_errs;
    bit exp_lock_first;
    bit exp_lock_end;
    bit chk_win;
  } frame_vec_t;

  frame_vec_t vec[18];

  int n_cmp;
  int n_fail;

  // Reference model: positions are timestamp differences, lock is a run count.
  int n;
  int h_zero;
  int v_lines;
  bit p_hs, p_vs;
  bit acq, dirty, m_locked;
  int run;
  int e_x, e_y;
  bit e_act, e_fs, e_err;

  // Per-frame observations
  int fs_idx, f_errs, f_first_x, f_first_y;
  bit f_first_lock;
  int a_fx, a_fy, a_lx, a_ly;

  function automatic int sat(input int v);
    return (v > 1023) ? 1023 : v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    p_hs     = 1'b1;
    p_vs     = 1'b1;
    h_zero   = n;
    v_lines  = 0;
    acq      = 1'b0;
    dirty    = 1'b0;
    run      = 0;
    m_locked = 1'b0;
  endtask

  task automatic model_step(input bit hs, input bit vs);
    bit hf, hr, vf, vr, tmo, err;
    int hb;
    hf  = p_hs && !hs;
    hr  = !p_hs && hs;
    vf  = p_vs && !vs;
    vr  = !p_vs && vs;
    hb  = sat(n - h_zero);
    tmo = !hf && (hb == 1022);
    err = (hf && (hb + 1 != HT)) || (hr && (hb + 1 != HS)) || tmo ||
          (vf && (v_lines + 1 != VT)) || (vr && (v_lines + 1 != VS)) ||
          ((vf || vr) && !hf);
    e_err = acq && err;
    if (!acq) begin
      if (vf) begin
        acq = 1'b1; run = 0; dirty = 1'b0;
      end
    end else if (m_locked) begin
      if (err) begin
        acq = 1'b0; m_locked = 1'b0;
      end
    end else if (tmo) begin
      acq = 1'b0;
    end else if (vf) begin
      run   = (!dirty && !err) ? run + 1 : 0;
      dirty = 1'b0;
      if (run >= LF) m_locked = 1'b1;
    end else if (err) begin
      dirty = 1'b1;
    end
    if (hf) h_zero = n + 1;
    if (vf) v_lines = 0;
    else if (hf) v_lines = sat(v_lines + 1);
    n++;
    e_x   = sat(n - h_zero);
    e_y   = v_lines;
    e_fs  = vf;
    e_act = m_locked && (e_x >= XLO) && (e_x < XHI) && (e_y >= YLO) && (e_y < YHI);
    p_hs  = hs;
    p_vs  = vs;
  endtask

  task automatic tick(input bit hs, input bit vs);
    int exp_v, act_v;
    @(negedge clk);
    hs_in = hs;
    vs_in = vs;
    @(posedge clk);
    model_step(hs, vs);
    #1;
    exp_v = (e_x << 14) | (e_y << 4) | (int'(e_act) << 3) | (int'(m_locked) << 2) |
            (int'(e_fs) << 1) | int'(e_err);
    act_v = int'({x, y, active, locked, frame_start, sync_err});
    check($sformatf("cycle%0d_xy_act_lock_fs_err", n), act_v, exp_v);
    if (sync_err) f_errs++;
    if (fs_idx == 0) begin
      f_first_lock = locked;
      f_first_x    = int'(x);
      f_first_y    = int'(y);
    end
    if (active) begin
      if (a_fx < 0) begin
        a_fx = int'(x); a_fy = int'(y);
      end
      a_lx = int'(x); a_ly = int'(y);
    end
    fs_idx++;
  endtask

  task automatic send_line(input int len, input int sw, input bit vsv, input int vdel);
    for (int c = 0; c < len; c++) begin
      tick((c < sw) ? 1'b0 : 1'b1, (c < vdel) ? bit'(vs_in) : vsv);
    end
  endtask

  task automatic send_frame(input int vsl, input int bl, input int blen,
                            input int bsw, input int vdel);
    fs_idx = 0; f_errs = 0; a_fx = -1; a_fy = -1; a_lx = -1; a_ly = -1;
    for (int l = 0; l < VT; l++) begin
      send_line((l == bl) ? blen : HT, (l == bl) ? bsw : HS,
                (l < vsl) ? 1'b0 : 1'b1, (l == 0) ? vdel : 0);
    end
  endtask

  initial begin
    // vs_lines, bad_line, bad_len, bad_sw, vf_delay, errs, lock_first, lock_end, win
    vec[0]  = '{2, -1, HT,     HS, 0, 0, 1'b0, 1'b0, 1'b0};
    vec[1]  = '{2, -1, HT,     HS, 0, 0, 1'b0, 1'b0, 1'b0};
    vec[2]  = '{2, -1, HT,     HS, 0, 0, 1'b1, 1'b1, 1'b1};
    vec[3]  = '{2, -1, HT,     HS, 0, 0, 1'b1, 1'b1, 1'b1};
    vec[4]  = '{2,  5, HT + 1, HS, 0, 1, 1'b1, 1'b0, 1'b0};
    vec[5]  = '{2, -1, HT,     HS, 0, 0, 1'b0, 1'b0, 1'b0};
    vec[6]  = '{2, -1, HT,     HS, 0, 0, 1'b0, 1'b0, 1'b0};
    vec[7]  = '{2, -1, HT,     HS, 0, 0, 1'b1, 1'b1, 1'b0};
    vec[8]  = '{3, -1, HT,     HS, 0, 1, 1'b1, 1'b0, 1'b0};
    vec[9]  = '{2, -1, HT,     HS, 0, 0, 1'b0, 1'b0, 1'b0};
    vec[10] = '{3, -1, HT,     HS, 0, 1, 1'b0, 1'b0, 1'b0};
    vec[11] = '{2, -1, HT,     HS, 0, 0, 1'b0, 1'b0, 1'b0};
    vec[12] = '{2, -1, HT,     HS, 0, 0, 1'b0, 1'b0, 1'b0};
    vec[13] = '{2, -1, HT,     HS, 0, 0, 1'b1, 1'b1, 1'b0};
    vec[14] = '{2, -1, HT,     HS, 5, 1, 1'b1, 1'b0, 1'b0};
    vec[15] = '{2, -1, HT,     HS, 0, 0, 1'b0, 1'b0, 1'b0};
    vec[16] = '{2, -1, HT,     HS, 0, 0, 1'b0, 1'b0, 1'b0};
    vec[17] = '{2, -1, HT,     HS, 0, 0, 1'b1, 1'b1, 1'b0};

    n_cmp = 0; n_fail = 0; n = 0; fs_idx = 1;
    rst = 1'b1; hs_in = 1'b1; vs_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", int'({x, y, active, locked, frame_start, sync_err}), 0);
    rst = 1'b0;
    model_reset();

    foreach (vec[i]) begin
      send_frame(vec[i].vs_lines, vec[i].bad_line, vec[i].bad_len, vec[i].bad_sw,
                 vec[i].vf_delay);
      check($sformatf("f%0d_sync_err_pulses", i), f_errs, vec[i].exp_errs);
      check($sformatf("f%0d_locked_first", i), int'(f_first_lock), int'(vec[i].exp_lock_first));
      check($sformatf("f%0d_locked_end", i), int'(locked), int'(vec[i].exp_lock_end));
      if (vec[i].vf_delay == 0)
        check($sformatf("f%0d_xy_at_vfall", i), (f_first_x << 10) | f_first_y, 0);
      if (vec[i].chk_win) begin
        check($sformatf("f%0d_active_first_xy", i), (a_fx << 10) | a_fy, (XLO << 10) | YLO);
        check($sformatf("f%0d_active_last_xy", i), (a_lx << 10) | a_ly,
              ((XHI - 1) << 10) | (YHI - 1));
      end
    end

    // hsync held high while locked: one timeout error 1023 samples after the last hfall
    begin
      int errs, err_at, x_err;
      errs = 0; err_at = -1; x_err = -1;
      for (int k = 0; k < 1100; k++) begin
        tick(1'b1, 1'b1);
        if (sync_err) begin
          errs++;
          if (err_at < 0) begin
            err_at = k; x_err = int'(x);
          end
        end
      end
      check("timeout_pulses", errs, 1);
      check("timeout_cycle", err_at, 1023 - HT);
      check("timeout_x_at_err", x_err, 1023);
      check("timeout_x_hold", int'(x), 1023);
      check("timeout_unlocked", int'(locked), 0);
    end

    repeat (3) send_frame(2, -1, HT, HS, 0);
    check("relock_after_timeout", int'(locked), 1);

    // Async reset mid-line, no clock edge between assert and check
    for (int l = 0; l < 3; l++) send_line(HT, HS, (l < VS) ? 1'b0 : 1'b1, 0);
    for (int c = 0; c < 10; c++) tick((c < HS) ? 1'b0 : 1'b1, 1'b1);
    check("pre_reset_locked", int'(locked), 1);
    #1 rst = 1'b1;
    #1;
    check("async_reset_outputs", int'({x, y, active, locked, frame_start, sync_err}), 0);
    rst = 1'b0;
    model_reset();
    for (int c = 10; c < HT; c++) tick(1'b1, 1'b1);
    for (int l = 4; l < VT; l++) send_line(HT, HS, 1'b1, 0);
    send_frame(2, -1, HT, HS, 0);
    check("post_reset_f1_locked_end", int'(locked), 0);
    send_frame(2, -1, HT, HS, 0);
    check("post_reset_f2_locked_first", int'(f_first_lock), 0);
    check("post_reset_f2_locked_end", int'(locked), 0);
    send_frame(2, -1, HT, HS, 0);
    check("post_reset_f3_locked_first", int'(f_first_lock), 1);

    // Randomized frames checked cycle by cycle against the model
    for (int f = 0; f < 30; f++) begin
      int r, vsl, bl, blen, bsw, vdel;
      r = int'($urandom_range(0, 9));
      vsl = VS; bl = -1; blen = HT; bsw = HS; vdel = 0;
      case (r)
        0: begin
          bl   = int'($urandom_range(1, VT - 1));
          blen = HT + (($urandom_range(0, 1) == 1) ? 1 : -1) * int'($urandom_range(1, 3));
        end
        1: vsl = ($urandom_range(0, 1) == 1) ? 1 : 3;
        2: vdel = int'($urandom_range(1, 6));
        3: begin
          bl  = int'($urandom_range(1, VT - 1));
          bsw = HS + (($urandom_range(0, 1) == 1) ? 1 : -1);
        end
        4: begin
          int gap;
          gap = int'($urandom_range(1, 50));
          for (int g = 0; g < gap; g++) tick(1'b1, 1'b1);
        end
        default: ;
      endcase
      send_frame(vsl, bl, blen, bsw, vdel);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
